// File: rtl/vgalcd_timdet.sv
// vgalcd_timdet: measures incoming hsync/vsync/de timing per axis and flags lock on two identical frames
module vgalcd_timdet #(
  parameter int TB_WIDTH = 8,
  parameter int VB_WIDTH = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                pclk_en_i,
  input  logic                hpol_i,
  input  logic                vpol_i,
  input  logic                hsync_i,
  input  logic                vsync_i,
  input  logic                de_i,
  output logic [TB_WIDTH-1:0] hbpsize_o,
  output logic [TB_WIDTH-1:0] hsnsize_o,
  output logic [TB_WIDTH-1:0] hfpsize_o,
  output logic [VB_WIDTH-1:0] hvlen_o,
  output logic [TB_WIDTH-1:0] vbpsize_o,
  output logic [TB_WIDTH-1:0] vsnsize_o,
  output logic [TB_WIDTH-1:0] vfpsize_o,
  output logic [VB_WIDTH-1:0] vvlen_o,
  output logic                frame_o,
  output logic                lock_o,
  output logic                err_o
);
  localparam logic [VB_WIDTH-1:0] TMAX = VB_WIDTH'((1 << TB_WIDTH) - 1);
  localparam logic [VB_WIDTH-1:0] VMAX = '1;
  typedef enum logic [2:0] {IDLE, SN, BP, VIS, FP} st_t;
  st_t h_st, h_nx, v_st, v_nx;
  logic tick, hs, vs, hs_q, vs_q, de_q, hr, hf, vr, vf, dr, df, h_edge, line_ev, had_de;
  logic h_err, v_err, v_soft, h_sat, v_sat, fatal, commit, commit_q, have_prev;
  logic cap_hsn, cap_hbp, cap_hvl, cap_hfp, cap_vsn, cap_vbp;
  logic [VB_WIDTH-1:0] h_cnt, v_cnt, v_blk, v_cnt_a, v_blk_a, h_lim, v_lim;
  logic [TB_WIDTH-1:0] c_hbp, c_hsn, c_hfp, c_vbp, c_vsn, c_vfp;
  logic [VB_WIDTH-1:0] c_hvl, c_vvl;
  assign tick = en_i & pclk_en_i;
  assign hs = hsync_i ^ hpol_i;
  assign vs = vsync_i ^ vpol_i;
  assign hr = tick & hs & ~hs_q;
  assign hf = tick & ~hs & hs_q;
  assign vr = tick & vs & ~vs_q;
  assign vf = tick & ~vs & vs_q;
  assign dr = tick & de_i & ~de_q;
  assign df = tick & ~de_i & de_q;
  assign h_edge = hr | hf | dr | df;
  assign line_ev = hr & (h_st != IDLE);
  assign h_lim = (h_st == VIS) ? VMAX : TMAX;
  assign v_lim = (v_st == VIS) ? VMAX : TMAX;
  assign h_sat = tick & ~h_edge & (h_st != IDLE) & (h_cnt == h_lim - 1'b1);
  assign v_cnt_a = v_cnt + VB_WIDTH'(line_ev & ((v_st != VIS) | had_de));
  assign v_blk_a = (line_ev & had_de) ? '0 : v_blk + VB_WIDTH'(line_ev & (v_st == VIS));
  assign v_sat = line_ev & (v_st != IDLE) & ((v_cnt_a == v_lim) | ((v_st == VIS) & (v_blk_a == TMAX)));
  always_ff @(posedge clk_i)
    if (rst_i | ~en_i | fatal) begin
      h_st <= IDLE;
      v_st <= IDLE;
    end else if (tick) begin
      h_st <= h_nx;
      v_st <= v_nx;
    end
  always_comb begin
    h_nx = h_st;
    h_err = 1'b0;
    case (h_st)
      IDLE: h_nx = hr ? SN : IDLE;
      SN: begin
        h_err = dr | df | hr;
        h_nx = hf ? BP : SN;
      end
      BP: begin
        h_err = df | hf | (hr & dr);
        h_nx = hr ? SN : dr ? VIS : BP;
      end
      VIS: begin
        h_err = hr | dr;
        h_nx = df ? FP : VIS;
      end
      FP: begin
        h_err = dr | df | hf;
        h_nx = hr ? SN : FP;
      end
      default: h_nx = IDLE;
    endcase
  end
  always_comb begin
    v_nx = v_st;
    v_err = 1'b0;
    case (v_st)
      IDLE: v_nx = vr ? SN : IDLE;
      SN: begin
        v_err = dr;
        v_nx = vf ? BP : SN;
      end
      BP: v_nx = vr ? SN : dr ? VIS : BP;
      VIS: v_nx = vr ? SN : VIS;
      default: v_nx = IDLE;
    endcase
  end
  always_comb begin
    fatal = h_err | v_err | h_sat | v_sat;
    v_soft = (v_st == BP) & vr & ~fatal;
    commit = (v_st == VIS) & vr & ~fatal;
    cap_hsn = (h_st == SN) & hf & ~fatal;
    cap_hbp = (h_st == BP) & dr & ~fatal;
    cap_hvl = (h_st == VIS) & df & ~fatal;
    cap_hfp = (h_st == FP) & hr & ~fatal;
    cap_vsn = (v_st == SN) & vf & ~fatal;
    cap_vbp = (v_st == BP) & dr & ~vr & ~fatal;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {hs_q, vs_q, de_q, had_de} <= '0;
      {h_cnt, v_cnt, v_blk} <= '0;
      {c_hbp, c_hsn, c_hfp, c_hvl, c_vbp, c_vsn, c_vfp, c_vvl} <= '0;
      {hbpsize_o, hsnsize_o, hfpsize_o, hvlen_o, vbpsize_o, vsnsize_o, vfpsize_o, vvlen_o} <= '0;
      {frame_o, lock_o, err_o, commit_q, have_prev} <= '0;
    end else begin
      frame_o <= commit_q;
      err_o <= fatal | v_soft;
      commit_q <= commit;
      if (tick) begin
        {hs_q, vs_q, de_q} <= {hs, vs, de_i};
        h_cnt <= h_edge ? VB_WIDTH'(1) : (h_cnt == VMAX) ? h_cnt : h_cnt + 1'b1;
        v_cnt <= (v_nx != v_st) ? '0 : v_cnt_a;
        v_blk <= (v_nx != v_st) ? '0 : v_blk_a;
        had_de <= dr | (had_de & ~line_ev);
      end
      if (cap_hsn) c_hsn <= h_cnt[TB_WIDTH-1:0];
      if (cap_hbp) c_hbp <= h_cnt[TB_WIDTH-1:0];
      if (cap_hvl) c_hvl <= h_cnt;
      if (cap_hfp) c_hfp <= h_cnt[TB_WIDTH-1:0];
      if (cap_vsn) c_vsn <= v_cnt_a[TB_WIDTH-1:0];
      if (cap_vbp) c_vbp <= v_cnt_a[TB_WIDTH-1:0];
      if (commit) begin
        c_vvl <= v_cnt_a;
        c_vfp <= v_blk_a[TB_WIDTH-1:0];
      end
      if (commit_q) begin
        {hbpsize_o, hsnsize_o, hfpsize_o, hvlen_o, vbpsize_o, vsnsize_o, vfpsize_o, vvlen_o} <=
          {c_hbp, c_hsn, c_hfp, c_hvl, c_vbp, c_vsn, c_vfp, c_vvl};
        lock_o <= have_prev & ({c_hbp, c_hsn, c_hfp, c_hvl, c_vbp, c_vsn, c_vfp, c_vvl} ==
          {hbpsize_o, hsnsize_o, hfpsize_o, hvlen_o, vbpsize_o, vsnsize_o, vfpsize_o, vvlen_o});
        have_prev <= 1'b1;
      end
      if (~en_i | fatal) begin
        lock_o <= 1'b0;
        have_prev <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vgalcd_timdet.sv
// tb_vgalcd_timdet: directed self-checking bench for the video timing detector
module tb_vgalcd_timdet;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic en_i = 1'b1;
  logic pclk_en_i = 1'b1;
  logic hpol_i = 1'b0;
  logic vpol_i = 1'b0;
  logic hsync_i = 1'b0;
  logic vsync_i = 1'b0;
  logic de_i = 1'b0;
  logic [7:0] hbpsize_o, hsnsize_o, hfpsize_o, vbpsize_o, vsnsize_o, vfpsize_o;
  logic [11:0] hvlen_o, vvlen_o;
  logic frame_o, lock_o, err_o;
  int n_chk = 0;
  int n_fail = 0;
  int n_frame = 0;
  int n_errp = 0;
  int div = 1;
  int err_at = 0;
  int f0, e0;
  always #5 clk_i = ~clk_i;
  vgalcd_timdet dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .pclk_en_i(pclk_en_i),
    .hpol_i(hpol_i), .vpol_i(vpol_i), .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i),
    .hbpsize_o(hbpsize_o), .hsnsize_o(hsnsize_o), .hfpsize_o(hfpsize_o), .hvlen_o(hvlen_o),
    .vbpsize_o(vbpsize_o), .vsnsize_o(vsnsize_o), .vfpsize_o(vfpsize_o), .vvlen_o(vvlen_o),
    .frame_o(frame_o), .lock_o(lock_o), .err_o(err_o)
  );
  always @(negedge clk_i) begin
    if (frame_o) n_frame <= n_frame + 1;
    if (err_o) n_errp <= n_errp + 1;
  end
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_set(input string tag, input int hbp, input int hsn, input int hfp, input int hvl,
                         input int vbp, input int vsn, input int vfp, input int vvl, input int lk);
    chk({tag, " hbp"}, hbpsize_o, hbp);
    chk({tag, " hsn"}, hsnsize_o, hsn);
    chk({tag, " hfp"}, hfpsize_o, hfp);
    chk({tag, " hvlen"}, hvlen_o, hvl);
    chk({tag, " vbp"}, vbpsize_o, vbp);
    chk({tag, " vsn"}, vsnsize_o, vsn);
    chk({tag, " vfp"}, vfpsize_o, vfp);
    chk({tag, " vvlen"}, vvlen_o, vvl);
    chk({tag, " lock"}, lock_o, lk);
  endtask
  task automatic tick(input bit hs, input bit vs, input bit de);
    for (int k = 0; k < div; k++) begin
      @(negedge clk_i);
      hsync_i = hs ^ hpol_i;
      vsync_i = vs ^ vpol_i;
      de_i = de;
      pclk_en_i = (k == div - 1);
    end
  endtask
  task automatic line(input bit vs, input bit vis, input int hvl);
    for (int t = 0; t < 9 + hvl; t++) tick(t < 2, vs, vis && t >= 6 && t < 6 + hvl);
  endtask
  task automatic frame(input int hvl, input bit bad);
    line(1, bad, hvl);
    repeat (2) line(0, 0, hvl);
    repeat (4) line(0, 1, hvl);
    line(0, 0, hvl);
  endtask
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    tick(0, 0, 0);
    tick(0, 0, 0);
    rst_i = 1'b0;
  endtask
  initial begin
    do_reset();
    chk_set("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset frame", frame_o, 0);
    chk("reset err", err_o, 0);
    f0 = n_frame;
    frame(16, 0);
    frame(16, 0);
    chk("s1 frames", n_frame - f0, 1);
    chk_set("s1 first", 4, 2, 3, 16, 2, 1, 1, 4, 0);
    frame(16, 0);
    chk("s1 frames2", n_frame - f0, 2);
    chk_set("s1 second", 4, 2, 3, 16, 2, 1, 1, 4, 1);
    chk("s1 errs", n_errp, 0);
    frame(15, 0);
    chk_set("s3 old", 4, 2, 3, 16, 2, 1, 1, 4, 1);
    frame(15, 0);
    chk_set("s3 change", 4, 2, 3, 15, 2, 1, 1, 4, 0);
    frame(15, 0);
    chk_set("s3 relock", 4, 2, 3, 15, 2, 1, 1, 4, 1);
    div = 3;
    do_reset();
    chk_set("s2 reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    f0 = n_frame;
    frame(16, 0);
    frame(16, 0);
    chk_set("s2 first", 4, 2, 3, 16, 2, 1, 1, 4, 0);
    frame(16, 0);
    chk_set("s2 second", 4, 2, 3, 16, 2, 1, 1, 4, 1);
    chk("s2 frames", n_frame - f0, 2);
    div = 1;
    hpol_i = 1'b1;
    vpol_i = 1'b1;
    do_reset();
    frame(16, 0);
    frame(16, 0);
    chk_set("s4 first", 4, 2, 3, 16, 2, 1, 1, 4, 0);
    frame(16, 0);
    chk_set("s4 second", 4, 2, 3, 16, 2, 1, 1, 4, 1);
    chk("s4 errs", n_errp, 0);
    e0 = n_errp;
    f0 = n_frame;
    for (int i = 1; i <= 300; i++) begin
      tick(1, 0, 0);
      @(posedge clk_i);
      #1;
      if (err_o && err_at == 0) err_at = i;
    end
    repeat (5) tick(0, 0, 0);
    chk("s5 err tick", err_at, 255);
    chk("s5 err pulses", n_errp - e0, 1);
    chk("s5 frames", n_frame - f0, 0);
    chk_set("s5 held", 4, 2, 3, 16, 2, 1, 1, 4, 0);
    frame(16, 0);
    frame(16, 0);
    frame(16, 0);
    chk_set("s6 lock", 4, 2, 3, 16, 2, 1, 1, 4, 1);
    line(1, 0, 16);
    repeat (2) line(0, 0, 16);
    repeat (2) line(0, 1, 16);
    do_reset();
    chk_set("s6 reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e0 = n_errp;
    f0 = n_frame;
    frame(16, 1);
    chk("s6 de in sn err", n_errp - e0, 1);
    chk("s6 no frame", n_frame - f0, 0);
    frame(16, 0);
    frame(16, 0);
    chk_set("s6 first", 4, 2, 3, 16, 2, 1, 1, 4, 0);
    frame(16, 0);
    chk_set("s6 relock", 4, 2, 3, 16, 2, 1, 1, 4, 1);
    chk("s6 frames", n_frame - f0, 2);
    chk("s6 errs", n_errp - e0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
